// File: rtl/control_unit_if.sv
// control_unit_if: control-unit <-> datapath bundle. Inputs to the sequencer are Ir, Flags,
// MemReady (and Irq when INTERRUPT_EN is defined); all strobes, selects, StatusReg, CFlag
// and Halted are driven by the sequencer. master = control unit, slave = datapath side.
interface control_unit_if;
  logic [15:0] Ir;
  logic [3:0]  Flags;
  logic        MemReady;
`ifdef INTERRUPT_EN
  logic        Irq;
`endif
  logic        MemReq, MemRnW;
  logic        IrWe, PcWe, LrWe, RegWe, AluWe;
  logic        AluEn, MemEn, PcEn, LrEn, StatusRegEn;
  logic        Op1Sel;
  logic [1:0]  Op2Sel;
  logic        ImmSel;
  logic [1:0]  Rs1Sel, RwSel, AluOR;
  logic [2:0]  PcSel;
  logic        LrSel, WdSel;
  logic [3:0]  StatusReg;
  logic        CFlag, Halted;
  modport master (
`ifdef INTERRUPT_EN
    input  Irq,
`endif
    input  Ir, Flags, MemReady,
    output MemReq, MemRnW, IrWe, PcWe, LrWe, RegWe, AluWe,
    output AluEn, MemEn, PcEn, LrEn, StatusRegEn,
    output Op1Sel, Op2Sel, ImmSel, Rs1Sel, RwSel, AluOR, PcSel, LrSel, WdSel,
    output StatusReg, CFlag, Halted
  );
  modport slave (
`ifdef INTERRUPT_EN
    output Irq,
`endif
    output Ir, Flags, MemReady,
    input  MemReq, MemRnW, IrWe, PcWe, LrWe, RegWe, AluWe,
    input  AluEn, MemEn, PcEn, LrEn, StatusRegEn,
    input  Op1Sel, Op2Sel, ImmSel, Rs1Sel, RwSel, AluOR, PcSel, LrSel, WdSel,
    input  StatusReg, CFlag, Halted
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: multi-cycle FSM sequencer for the 16-bit datapath.
// Ports: Clock (rising edge), nReset (async active-low), bus (control_unit_if.master:
// Ir/Flags/MemReady in, every datapath strobe/select plus StatusReg/CFlag/Halted out).
// Optional feature macro INTERRUPT_EN adds the Irq input, the IRQ state and the IE bit.
module control_unit #(
  parameter int WAIT_LIMIT = 8,
  parameter int WCW        = 4
) (
  input logic             Clock,
  input logic             nReset,
  control_unit_if.master  bus
);
  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_WB, S_MEM, S_BR, S_HALT
`ifdef INTERRUPT_EN
    , S_IRQ
`endif
  } state_t;
  state_t           r_state;
  logic [WCW-1:0]   r_wait;
  logic [3:0]       r_status;
  logic [2:0]       w_cls;
  logic [1:0]       w_sub;
  logic             w_alu_cls, w_mem_cls, w_ldw, w_bcc, w_bl, w_ret, w_rdsr;
  logic [7:0]       w_cond_vec;
  logic             w_taken, w_wait_done, w_unused_ir;
  logic             w_fetch, w_exec, w_wb, w_mem, w_br, w_halt, w_irq, w_ldw_done;
  state_t           w_entry, w_ret_entry, w_exec_next;
  assign w_cls       = bus.Ir[15:13];
  assign w_sub       = bus.Ir[12:11];
  assign w_unused_ir = ^bus.Ir[7:0];
  assign w_alu_cls   = (w_cls == 3'b000) || (w_cls == 3'b001) || (w_cls == 3'b101);
  assign w_mem_cls   = w_cls[2:1] == 2'b01;
  assign w_ldw       = w_cls == 3'b010;
  assign w_bcc       = w_cls == 3'b110;
  assign w_bl        = (w_cls == 3'b111) && (w_sub == 2'b00);
  assign w_ret       = (w_cls == 3'b111) && (w_sub == 2'b01);
  assign w_rdsr      = (w_cls == 3'b111) && (w_sub == 2'b10);
  // Branch conditions indexed by Ir[10:8] over the latched {Z,N,C,V}
  assign w_cond_vec  = {1'b0, ~r_status[2], r_status[2], ~r_status[1], r_status[1],
                        ~r_status[3], r_status[3], 1'b1};
  assign w_taken     = w_cond_vec[bus.Ir[10:8]];
  assign w_wait_done = r_wait == WCW'(WAIT_LIMIT - 1);
`ifdef INTERRUPT_EN
  logic r_ie;
  assign w_entry     = (bus.Irq && r_ie) ? S_IRQ : S_FETCH;
  // RET re-enables interrupts, so a pending Irq is taken at its own FETCH entry
  assign w_ret_entry = bus.Irq ? S_IRQ : S_FETCH;
  assign w_irq       = r_state == S_IRQ;
`else
  assign w_entry     = S_FETCH;
  assign w_ret_entry = S_FETCH;
  assign w_irq       = 1'b0;
`endif
  assign w_exec_next = w_alu_cls ? S_WB :
                       w_mem_cls ? S_MEM :
                       ((w_bcc && w_taken) || w_bl) ? S_BR :
                       w_ret ? w_ret_entry : w_entry;
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state  <= S_RESET;
      r_wait   <= '0;
      r_status <= '0;
`ifdef INTERRUPT_EN
      r_ie     <= 1'b1;
`endif
    end else begin
      r_wait <= '0;
      case (r_state)
        S_RESET:  r_state <= w_entry;
        S_FETCH:  if (bus.MemReady) r_state <= S_DECODE;
                  else if (w_wait_done) r_state <= S_HALT;
                  else r_wait <= r_wait + 1'b1;
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          r_state <= w_exec_next;
`ifdef INTERRUPT_EN
          if (w_ret) r_ie <= 1'b1;
`endif
        end
        S_WB: begin
          if (w_alu_cls) r_status <= bus.Flags;
          r_state <= w_entry;
        end
        S_MEM:    if (bus.MemReady) r_state <= w_entry;
                  else if (w_wait_done) r_state <= S_HALT;
                  else r_wait <= r_wait + 1'b1;
        S_BR:     r_state <= w_entry;
        S_HALT:   r_state <= S_HALT;
`ifdef INTERRUPT_EN
        S_IRQ: begin
          r_ie    <= 1'b0;
          r_state <= S_FETCH;
        end
`endif
        default:  r_state <= S_RESET;
      endcase
    end
  end
  assign w_fetch    = r_state == S_FETCH;
  assign w_exec     = r_state == S_EXEC;
  assign w_wb       = r_state == S_WB;
  assign w_mem      = r_state == S_MEM;
  assign w_br       = r_state == S_BR;
  assign w_halt     = r_state == S_HALT;
  assign w_ldw_done = w_mem && w_ldw && bus.MemReady;
  assign bus.MemReq      = w_fetch || w_mem;
  assign bus.MemRnW      = w_fetch || (w_mem && !bus.Ir[13]);
  assign bus.IrWe        = w_fetch;
  assign bus.PcWe        = (w_fetch && bus.MemReady) || (w_exec && w_ret) || w_br || w_irq;
  assign bus.LrWe        = (w_exec && w_bl) || w_irq;
  assign bus.RegWe       = w_wb || (w_exec && w_rdsr) || w_ldw_done;
  assign bus.AluWe       = w_exec && (w_alu_cls || w_mem_cls || (w_bcc && w_taken) || w_bl);
  // The load's data cycle hands the system bus to memory, so the ALU releases it
  assign bus.AluEn       = w_wb || w_br || (w_mem && !w_ldw_done);
  assign bus.MemEn       = w_fetch || w_ldw_done;
  assign bus.PcEn        = 1'b0;
  assign bus.LrEn        = 1'b0;
  assign bus.StatusRegEn = w_exec && w_rdsr;
  assign bus.Op1Sel      = w_exec && ((w_bcc && w_taken) || w_bl);
  assign bus.Op2Sel      = (w_exec && (w_cls == 3'b000)) ? 2'd1 : 2'd0;
  assign bus.ImmSel      = w_exec && ((w_cls == 3'b001) || w_mem_cls);
  assign bus.Rs1Sel      = 2'd0;
  assign bus.RwSel       = (w_exec && (w_cls == 3'b101)) ? 2'd1 : 2'd0;
  assign bus.AluOR       = 2'b00;
  assign bus.PcSel       = w_br ? 3'd1 : (w_exec && w_ret) ? 3'd3 : w_irq ? 3'd7 : 3'd0;
  assign bus.LrSel       = (w_exec && w_bl) || w_irq;
  assign bus.WdSel       = (w_exec && w_rdsr) || w_ldw_done;
  assign bus.StatusReg   = r_status;
  assign bus.CFlag       = r_status[1];
  assign bus.Halted      = w_halt;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vector bench for control_unit
module tb_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq_drv = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  control_unit_if bus();
  control_unit dut (.Clock(clk), .nReset(rst_n), .bus(bus));
`ifdef INTERRUPT_EN
  assign bus.Irq = irq_drv;
`endif
  localparam logic [27:0] HLT = 28'd1 << 0, WDS = 28'd1 << 1, LRS = 28'd1 << 2;
  localparam logic [27:0] PCS_ALU = 28'd1 << 3, PCS_LR = 28'd3 << 3, PCS_VEC = 28'd7 << 3;
  localparam logic [27:0] RWS1 = 28'd1 << 8, IMM = 28'd1 << 12, OP2_RD2 = 28'd1 << 13;
  localparam logic [27:0] OP1 = 28'd1 << 15, SREN = 28'd1 << 16, MEN = 28'd1 << 19;
  localparam logic [27:0] AEN = 28'd1 << 20, AWE = 28'd1 << 21, RWE = 28'd1 << 22;
  localparam logic [27:0] LWE = 28'd1 << 23, PWE = 28'd1 << 24, IWE = 28'd1 << 25;
  localparam logic [27:0] RNW = 28'd1 << 26, MREQ = 28'd1 << 27;
  localparam logic [27:0] F_WAIT = MREQ | RNW | MEN | IWE;
  localparam logic [27:0] F_RDY = F_WAIT | PWE;
  localparam logic [27:0] BR = AEN | PCS_ALU | PWE;
  localparam logic [27:0] WB = AEN | RWE;
  localparam logic [27:0] IRQ = LRS | LWE | PCS_VEC | PWE;
  typedef struct {
    logic [15:0] ir;
    logic [3:0]  fl;
    logic        rdy;
    logic [27:0] exp;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [27:0] outs();
    return {bus.MemReq, bus.MemRnW, bus.IrWe, bus.PcWe, bus.LrWe, bus.RegWe, bus.AluWe,
            bus.AluEn, bus.MemEn, bus.PcEn, bus.LrEn, bus.StatusRegEn, bus.Op1Sel,
            bus.Op2Sel, bus.ImmSel, bus.Rs1Sel, bus.RwSel, bus.AluOR, bus.PcSel,
            bus.LrSel, bus.WdSel, bus.Halted};
  endfunction
  function automatic vec_t mk(logic [15:0] ir, logic [3:0] fl, logic rdy, logic [27:0] e);
    vec_t v;
    v.ir = ir; v.fl = fl; v.rdy = rdy; v.exp = e;
    return v;
  endfunction
  task automatic chk(string n, logic [27:0] act, logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic apply(logic [15:0] ir, logic [3:0] fl, logic rdy);
    bus.Ir = ir; bus.Flags = fl; bus.MemReady = rdy;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_outs", outs(), 28'd0);
    chk("reset_status", 28'(bus.StatusReg), 28'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic run_tbl(string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].ir, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("%s[%0d]", tag, i), outs(), tbl[i].exp);
      chk($sformatf("%s_onehot[%0d]", tag, i),
          28'($countones({bus.AluEn, bus.MemEn, bus.PcEn, bus.LrEn, bus.StatusRegEn}) <= 1), 28'd1);
      @(negedge clk);
    end
  endtask
  initial begin
    bus.Ir = '0; bus.Flags = '0; bus.MemReady = 1'b0;
    tbl = {};
    tbl.push_back(mk(16'hAC01, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hAC01, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'hAC01, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hAC01, 4'h0, 1'b1, AWE | RWS1));
    tbl.push_back(mk(16'hAC01, 4'h8, 1'b1, WB));
    tbl.push_back(mk(16'hC100, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'hC100, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hC100, 4'h0, 1'b1, OP1 | AWE));
    tbl.push_back(mk(16'hC100, 4'h0, 1'b1, BR));
    tbl.push_back(mk(16'h0000, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'h0000, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'h0000, 4'h0, 1'b1, OP2_RD2 | AWE));
    tbl.push_back(mk(16'h0000, 4'h0, 1'b1, WB));
    tbl.push_back(mk(16'hC100, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'hC100, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hC100, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'h4005, 4'h0, 1'b0, F_WAIT));
    tbl.push_back(mk(16'h4005, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'h4005, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'h4005, 4'h0, 1'b1, IMM | AWE));
    tbl.push_back(mk(16'h4005, 4'h0, 1'b0, AEN | MREQ | RNW));
    tbl.push_back(mk(16'h4005, 4'h0, 1'b0, AEN | MREQ | RNW));
    tbl.push_back(mk(16'h4005, 4'h0, 1'b0, AEN | MREQ | RNW));
    tbl.push_back(mk(16'h4005, 4'h0, 1'b1, MREQ | RNW | MEN | WDS | RWE));
    tbl.push_back(mk(16'h6005, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'h6005, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'h6005, 4'h0, 1'b1, IMM | AWE));
    tbl.push_back(mk(16'h6005, 4'h0, 1'b1, AEN | MREQ));
    tbl.push_back(mk(16'hE000, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'hE000, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hE000, 4'h0, 1'b1, LRS | LWE | OP1 | AWE));
    tbl.push_back(mk(16'hE000, 4'h0, 1'b1, BR));
    tbl.push_back(mk(16'hE800, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'hE800, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hE800, 4'h0, 1'b1, PCS_LR | PWE));
    tbl.push_back(mk(16'hF000, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'hF000, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hF000, 4'h0, 1'b1, SREN | WDS | RWE));
    tbl.push_back(mk(16'h2003, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'h2003, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'h2003, 4'h0, 1'b1, IMM | AWE));
    tbl.push_back(mk(16'h2003, 4'h2, 1'b1, WB));
    tbl.push_back(mk(16'hC300, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'hC300, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hC300, 4'h0, 1'b1, OP1 | AWE));
    tbl.push_back(mk(16'hC300, 4'h0, 1'b1, BR));
    tbl.push_back(mk(16'h8000, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'h8000, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'h8000, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hF800, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'hF800, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hF800, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hC700, 4'h0, 1'b1, F_RDY));
    do_reset();
    run_tbl("main");
    chk("status_after_ri", 28'(bus.StatusReg), 28'h2);
    chk("cflag", 28'(bus.CFlag), 28'd1);
    do_reset();
    apply(16'h0000, 4'h0, 1'b0);
    chk("halt_reset_state", outs(), 28'd0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      apply(16'h0000, 4'h0, 1'b0);
      chk($sformatf("halt_wait[%0d]", i), outs(), F_WAIT);
      @(negedge clk);
    end
    apply(16'h0000, 4'h0, 1'b1);
    chk("halted", outs(), HLT);
    @(negedge clk);
    chk("halt_ignores_ready", outs(), HLT);
    rst_n = 1'b0;
    #1;
    chk("halt_async_clear", outs(), 28'd0);
    tbl = {};
    tbl.push_back(mk(16'h0000, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'h0000, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'h0000, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'h0000, 4'h0, 1'b1, OP2_RD2 | AWE));
    do_reset();
    run_tbl("midrst");
    apply(16'h0000, 4'hF, 1'b1);
    chk("midrst_wb", outs(), WB);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", outs(), 28'd0);
    @(negedge clk);
    chk("midrst_status", 28'(bus.StatusReg), 28'd0);
`ifdef INTERRUPT_EN
    tbl = {};
    tbl.push_back(mk(16'hF800, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hF800, 4'h0, 1'b1, IRQ));
    tbl.push_back(mk(16'hF800, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'hF800, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hF800, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hE800, 4'h0, 1'b1, F_RDY));
    tbl.push_back(mk(16'hE800, 4'h0, 1'b1, 28'd0));
    tbl.push_back(mk(16'hE800, 4'h0, 1'b1, PCS_LR | PWE));
    tbl.push_back(mk(16'hF800, 4'h0, 1'b1, IRQ));
    tbl.push_back(mk(16'hF800, 4'h0, 1'b1, F_RDY));
    irq_drv = 1'b1;
    do_reset();
    run_tbl("irq");
    irq_drv = 1'b0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
